// File: rtl/ar_rr_arbiter_if.sv
// AR channel bundle between NUM_M masters and one slave AR port, plus the slave's burst-done pulse.
// The arbiter connects through the slave modport; the master modport is the upstream/downstream view.
interface ar_rr_arbiter_if #(
  parameter int NUM_M  = 4,
  parameter int DATA_W = 77
);
  logic [NUM_M*DATA_W-1:0] DATAi;
  logic [NUM_M-1:0]        VALIDi;
  logic [NUM_M-1:0]        READYi;
  logic [DATA_W-1:0]       DATAo;
  logic                    VALIDo;
  logic                    READYo;
  logic                    RDONE;

  modport slave (
    input  DATAi, VALIDi, READYo, RDONE,
    output READYi, DATAo, VALIDo
  );

  modport master (
    output DATAi, VALIDi, READYo, RDONE,
    input  READYi, DATAo, VALIDo
  );
endinterface

// File: rtl/ar_rr_arbiter.sv
// Round-robin arbiter sharing one AXI4 AR slave port among NUM_M masters, capping outstanding reads.
// Define AR_ARB_OUTREG_EN for a registered output slice that cuts the READYo->READYi path.
module ar_rr_arbiter #(
  parameter int NUM_M   = 4,
  parameter int DATA_W  = 77,
  parameter int MAX_OUT = 8
) (
  input  logic                     CLK,
  input  logic                     RESETn,
  ar_rr_arbiter_if.slave           bus,
  output logic [$clog2(NUM_M)-1:0] GNT_ID,
  output logic [7:0]               OUTSTD
);

  localparam int         ID_W    = $clog2(NUM_M);
  localparam logic [7:0] MAX_CNT = 8'(MAX_OUT);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state;
  logic [ID_W-1:0]   gnt_id;
  logic [7:0]        outstd;
  logic [DATA_W-1:0] slice_data [NUM_M];
  logic              sel_found;
  logic [ID_W-1:0]   sel_idx;
  logic [ID_W-1:0]   cand;
  logic              can_grant;
  logic              ar_hs;
  logic              cnt_dec;
`ifdef AR_ARB_OUTREG_EN
  logic [DATA_W-1:0] data_q;
`endif

  for (genvar k = 0; k < NUM_M; k++) begin : g_slice
    assign slice_data[k] = bus.DATAi[k*DATA_W +: DATA_W];
  end

  // Scan starts just after the last winner, so that winner drops to lowest priority.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= NUM_M; i++) begin
      cand = ID_W'((int'(gnt_id) + i) % NUM_M);
      if (!sel_found && bus.VALIDi[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  assign can_grant = (state == IDLE) && sel_found && (outstd < MAX_CNT);
  assign cnt_dec   = bus.RDONE && (outstd != 8'd0);

`ifdef AR_ARB_OUTREG_EN
  assign ar_hs = (state == BUSY) && bus.READYo;
`else
  assign ar_hs = (state == BUSY) && bus.VALIDi[gnt_id] && bus.READYo;
`endif

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state  <= IDLE;
      gnt_id <= ID_W'(NUM_M - 1);
      outstd <= 8'd0;
`ifdef AR_ARB_OUTREG_EN
      data_q <= '0;
`endif
    end else begin
      if (ar_hs && !cnt_dec && (outstd != 8'hFF)) begin
        outstd <= outstd + 8'd1;
      end else if (!ar_hs && cnt_dec) begin
        outstd <= outstd - 8'd1;
      end
      case (state)
        IDLE: begin
          if (can_grant) begin
            gnt_id <= sel_idx;
            state  <= BUSY;
`ifdef AR_ARB_OUTREG_EN
            data_q <= slice_data[sel_idx];
`endif
          end
        end
        BUSY: begin
          if (ar_hs) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are gated by reset so an abandoned BUSY transaction never leaks a READYi pulse.
  always_comb begin
    bus.READYi = '0;
    bus.VALIDo = 1'b0;
`ifdef AR_ARB_OUTREG_EN
    bus.DATAo = data_q;
    if (RESETn) begin
      if (can_grant) begin
        bus.READYi[sel_idx] = 1'b1;
      end
      bus.VALIDo = (state == BUSY);
    end
`else
    bus.DATAo = (state == BUSY) ? slice_data[gnt_id] : '0;
    if (RESETn && (state == BUSY)) begin
      bus.VALIDo         = bus.VALIDi[gnt_id];
      bus.READYi[gnt_id] = bus.READYo;
    end
`endif
  end

  assign GNT_ID = gnt_id;
  assign OUTSTD = outstd;

endmodule
